// File: rtl/pipe_pkg.sv
// Shared Y86-64 pipeline definitions: status codes, special icodes and status helpers.
package pipe_pkg;

  localparam int STAT_W  = 3;
  localparam int ICODE_W = 4;

  typedef enum logic [STAT_W-1:0] {
    BUB = 3'd0,
    AOK = 3'd1,
    HLT = 3'd2,
    ADR = 3'd3,
    INS = 3'd4
  } stat_e;

  localparam logic [ICODE_W-1:0] ICODE_NOP  = 4'h1;
  localparam logic [ICODE_W-1:0] ICODE_HALT = 4'h0;

  function automatic logic is_exception(input logic [STAT_W-1:0] stat);
    return (stat != AOK) && (stat != BUB);
  endfunction

  // Undefined codes 5..7 collapse to INS so downstream logic only sees legal values.
  function automatic logic [STAT_W-1:0] norm_stat(input logic [STAT_W-1:0] stat);
    return (stat > INS) ? INS : stat;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline register: icode, status and opaque payload with stall/bubble/freeze control.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 freeze,
  input  logic                 stall,
  input  logic                 bubble,
  input  logic [ICODE_W-1:0]   d_icode,
  input  logic [STAT_W-1:0]    d_stat,
  input  logic [PAYLOAD_W-1:0] d_payload,
  output logic [ICODE_W-1:0]   q_icode,
  output logic [STAT_W-1:0]    q_stat,
  output logic [PAYLOAD_W-1:0] q_payload
);

  // Freeze and stall both hold; stall outranks bubble when both are requested.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_icode   <= ICODE_NOP;
      q_stat    <= BUB;
      q_payload <= '0;
    end else if (!(freeze || stall)) begin
      if (bubble) begin
        q_icode   <= ICODE_NOP;
        q_stat    <= BUB;
        q_payload <= '0;
      end else begin
        q_icode   <= d_icode;
        q_stat    <= d_stat;
        q_payload <= d_payload;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Chain of Y86-64 pipeline registers (D..W) with exception freeze, retire counter and
// a sticky flag for contradictory stall/bubble requests.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int STAGES    = 4,
  parameter int PAYLOAD_W = 256,
  parameter int CNT_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    in_icode,
  input  logic [2:0]                    in_stat,
  input  logic [PAYLOAD_W-1:0]          in_payload,
  input  logic [STAGES-1:0]             stall,
  input  logic [STAGES-1:0]             bubble,
  output logic [4*STAGES-1:0]           stage_icode,
  output logic [3*STAGES-1:0]           stage_stat,
  output logic [PAYLOAD_W*STAGES-1:0]   stage_payload,
  output logic                          halted,
  output logic [2:0]                    exc_stat,
  output logic [CNT_W-1:0]              retire_count,
  output logic                          ctrl_err
);

  localparam int LAST = STAGES - 1;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [ICODE_W-1:0]   src_icode;
    logic [STAT_W-1:0]    src_stat;
    logic [PAYLOAD_W-1:0] src_payload;

    if (i == 0) begin : g_src_in
      assign src_icode   = in_icode;
      assign src_stat    = norm_stat(in_stat);
      assign src_payload = in_payload;
    end else begin : g_src_prev
      assign src_icode   = stage_icode[ICODE_W*(i-1) +: ICODE_W];
      assign src_stat    = stage_stat[STAT_W*(i-1) +: STAT_W];
      assign src_payload = stage_payload[PAYLOAD_W*(i-1) +: PAYLOAD_W];
    end

    pipe_stage_reg #(.PAYLOAD_W(PAYLOAD_W)) u_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .freeze    (halted),
      .stall     (stall[i]),
      .bubble    (bubble[i]),
      .d_icode   (src_icode),
      .d_stat    (src_stat),
      .d_payload (src_payload),
      .q_icode   (stage_icode[ICODE_W*i +: ICODE_W]),
      .q_stat    (stage_stat[STAT_W*i +: STAT_W]),
      .q_payload (stage_payload[PAYLOAD_W*i +: PAYLOAD_W])
    );
  end

  logic [STAT_W-1:0] last_stat;
  logic              retire_en;

  assign last_stat = stage_stat[STAT_W*LAST +: STAT_W];
  // An instruction retires on the edge that moves it out of W; saturate instead of wrapping.
  assign retire_en = !halted && (last_stat == AOK) && !stall[LAST] && (retire_count != '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted       <= 1'b0;
      exc_stat     <= BUB;
      retire_count <= '0;
      ctrl_err     <= 1'b0;
    end else begin
      if (!halted && is_exception(last_stat)) begin
        halted   <= 1'b1;
        exc_stat <= last_stat;
      end
      if (retire_en) begin
        retire_count <= retire_count + 1'b1;
      end
      if (|(stall & bubble)) begin
        ctrl_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised chain of Y86-64 pipeline registers (D, E, M, W by default) with per-stage stall/bubble control, status propagation and exception freeze.
- Replaces the hand-written f_reg/m_reg-style single-purpose registers.
- Sits between the fetch output and the hazard/control unit. Stage outputs feed decode, execute, memory and writeback logic.
- Adds a retire counter and a control-error flag so the processor top and bench can observe progress and halt.

Parameters:
- STAGES, 4, number of register stages; index 0 = D, STAGES-1 = W.
- PAYLOAD_W, 256, width of the opaque per-stage payload (ifun, rA, rB, valC, valP, valE, valM, ...).
- CNT_W, 32, width of the retire counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_icode  in  4  icode entering stage 0.
- in_stat  in  3  status entering stage 0.
- in_payload  in  PAYLOAD_W  payload entering stage 0.
- stall  in  STAGES  per-stage hold request.
- bubble  in  STAGES  per-stage NOP-insert request.
- stage_icode  out  4*STAGES  registered icode; stage i at bits [4i+3:4i].
- stage_stat  out  3*STAGES  registered status; stage i at bits [3i+2:3i].
- stage_payload  out  PAYLOAD_W*STAGES  registered payload, packed the same way.
- halted  out  1  chain frozen on an exception in the last stage.
- exc_stat  out  3  status that caused the freeze; BUB while not halted.
- retire_count  out  CNT_W  instructions retired from the last stage.
- ctrl_err  out  1  sticky flag: stall and bubble asserted on the same stage in the same cycle.

Behaviour:
- Stat codes:
  - BUB = 0
  - AOK = 1
  - HLT = 2
  - ADR = 3
  - INS = 4
  - 5 to 7 are treated as INS on entry.
- NOP icode = 4'h1.
- Reset: rst_n sampled low at a clk edge forces, on that edge and overriding every other input:
  - every stage to icode = NOP, stat = BUB, payload = 0;
  - halted = 0, exc_stat = BUB, retire_count = 0, ctrl_err = 0.
  - Reset asserted mid-operation discards all in-flight state, including a halt.
- Per stage i, each cycle with rst_n high and halted = 0:
  - stall[i]: hold the current contents.
  - else bubble[i]: load NOP / BUB / payload 0.
  - else load from the source. Stage 0's source is the in_* ports; stage i>0's source is stage i-1's registered value.
  - Latency: one cycle per stage, so an unstalled instruction appears at W STAGES cycles after presentation at in_*.
- stall[i] and bubble[i] both high: stall wins and ctrl_err sets. ctrl_err clears only on reset.
- A stalled stage i does not block stage i+1. If stage i+1 is neither stalled nor bubbled, it reloads stage i's held value (duplication). The hazard unit must bubble i+1 to avoid this; the chain does not enforce it.
- Exception freeze:
  - When the last stage holds a stat other than AOK or BUB, halted and exc_stat are registered on the next edge.
  - From that edge onward all stages hold, regardless of stall/bubble, until reset.
  - The freeze takes effect one cycle after the excepting instruction reaches W.
- Retire counting:
  - retire_count increments by 1 on each edge where the last stage holds AOK, halted = 0 and stall[STAGES-1] = 0.
  - The counter saturates at all-ones and does not wrap.
  - An HLT, ADR or INS reaching W does not count.
- Only stat and icode are interpreted; the payload passes through untouched.

Decomposition:
- Package pipe_pkg holds:
  - stat codes BUB, AOK, HLT, ADR, INS and STAT_W = 3;
  - ICODE_NOP = 4'h1 and ICODE_HALT = 4'h0;
  - a helper function is_exception(stat).
- Sub-module pipe_stage_reg:
  - one stage with payload width parameter, plus stall, bubble, freeze and rst_n;
  - instantiated STAGES times in a generate loop.
- Top level holds the freeze logic, the retire counter and ctrl_err.

Test Plan:
- Reset, then feed 6 AOK instructions (icode 2,3,6,...), no stall or bubble:
  - each appears at W exactly 4 cycles after entry;
  - retire_count = 6 after the last one drains; halted = 0.
- stall[0] high for 2 cycles together with bubble[1] during an instruction with icode 5 (load/use):
  - D holds icode 5; E shows NOP/BUB for 2 cycles;
  - no instruction is duplicated; retire_count counts each instruction once.
- Feed an HLT (icode 0, stat HLT) followed by 3 AOK instructions:
  - one cycle after HLT reaches W, halted = 1 and exc_stat = 2;
  - all stages frozen for 10 further cycles; retire_count is not incremented by the HLT.
- Feed an INS with stat 6:
  - it is treated as INS: exc_stat = 4 after it reaches W.
- Drive stall[2] and bubble[2] together for one cycle:
  - stage 2 holds its contents and ctrl_err = 1;
  - ctrl_err stays 1 through subsequent traffic until rst_n is pulsed low.
- While halted, drive rst_n low for 1 cycle:
  - all stages are NOP/BUB, halted = 0, counter = 0;
  - a new AOK stream retires normally.
